forward_scoreboard: RTL and testbench

//  Produces the forwarding controls consumed by the operand-select stage: rsFwd/rtFwd plus rsFwdData/rtFwdData.
//  It keeps a 3-slot shadow of in-flight destinations (EX, MEM, WB) and compares them against the ID-stage

---
 rtl/forward_scoreboard_if.sv | 46 ++++
 rtl/forward_scoreboard.sv | 114 +++++++++++
 tb/tb_forward_scoreboard.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/forward_scoreboard_if.sv
// ============================================================================
// Module      : forward_scoreboard_if
// Description : ID-stage, result and forwarding-control bundle for the
//               operand forwarding scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface forward_scoreboard_if #(
  parameter int REG_W  = 5,
  parameter int DATA_W = 32
);
  logic              hold;
  logic              flush;
  logic              idValid;
  logic [REG_W-1:0]  idRs;
  logic [REG_W-1:0]  idRt;
  logic              idUsesRs;
  logic              idUsesRt;
  logic              idRegWr;
  logic [REG_W-1:0]  idDest;
  logic              idIsLoad;
  logic [DATA_W-1:0] exResult;
  logic [DATA_W-1:0] memResult;
  logic [DATA_W-1:0] wbResult;
  logic              rsFwd;
  logic [DATA_W-1:0] rsFwdData;
  logic              rtFwd;
  logic [DATA_W-1:0] rtFwdData;
  logic              stall;

  // Pipeline side: drives ID fields and results, consumes forwarding controls
  modport master (
    output hold, flush, idValid, idRs, idRt, idUsesRs, idUsesRt,
           idRegWr, idDest, idIsLoad, exResult, memResult, wbResult,
    input  rsFwd, rsFwdData, rtFwd, rtFwdData, stall
  );

  modport slave (
    input  hold, flush, idValid, idRs, idRt, idUsesRs, idUsesRt,
           idRegWr, idDest, idIsLoad, exResult, memResult, wbResult,
    output rsFwd, rsFwdData, rtFwd, rtFwdData, stall
  );
endinterface

`default_nettype wire

// File: rtl/forward_scoreboard.sv
// ============================================================================
// Module      : forward_scoreboard
// Description : Shadows EX/MEM/WB destinations and produces rs/rt forwarding
//               selects, forwarded data and the load-use stall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module forward_scoreboard #(
  parameter int REG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  forward_scoreboard_if.slave   bus
);

  localparam int c_EX  = 0;
  localparam int c_MEM = 1;
  localparam int c_WB  = 2;

  logic [2:0]       r_v;
  logic [2:0]       r_wr;
  logic [2:0]       r_ld;
  logic [REG_W-1:0] r_dest [3];

  logic [2:0]       w_rs_hit;
  logic [2:0]       w_rt_hit;
  logic             w_stall;
  logic             w_ex_v;
  logic [DATA_W:0]  w_rs_sel;
  logic [DATA_W:0]  w_rt_sel;

  // $zero never matches, so a write to r0 can never be forwarded
  for (genvar s = 0; s < 3; s++) begin : g_slot_match
    assign w_rs_hit[s] = r_v[s] & r_wr[s] & (r_dest[s] == bus.idRs) & (bus.idRs != '0);
    assign w_rt_hit[s] = r_v[s] & r_wr[s] & (r_dest[s] == bus.idRt) & (bus.idRt != '0);
  end

  // Youngest producer first; a load in EX has no value yet and is skipped
  function automatic logic [DATA_W:0] f_pick(
    input logic              uses,
    input logic [2:0]        hit,
    input logic              ex_ld,
    input logic [DATA_W-1:0] ex_val,
    input logic [DATA_W-1:0] mem_val,
    input logic [DATA_W-1:0] wb_val
  );
    logic [DATA_W:0] sel;
    sel = '0;
    if (uses) begin
      if (hit[c_EX] & ~ex_ld) begin
        sel = {1'b1, ex_val};
      end else if (hit[c_MEM]) begin
        sel = {1'b1, mem_val};
      end else if (hit[c_WB]) begin
        sel = {1'b1, wb_val};
      end
    end
    return sel;
  endfunction

  always_comb begin
    w_rs_sel = f_pick(bus.idUsesRs, w_rs_hit, r_ld[c_EX],
                      bus.exResult, bus.memResult, bus.wbResult);
    w_rt_sel = f_pick(bus.idUsesRt, w_rt_hit, r_ld[c_EX],
                      bus.exResult, bus.memResult, bus.wbResult);
  end

  assign w_stall = bus.idValid & ~bus.flush &
                   ((bus.idUsesRs & w_rs_hit[c_EX] & r_ld[c_EX]) |
                    (bus.idUsesRt & w_rt_hit[c_EX] & r_ld[c_EX]));

  assign w_ex_v = bus.idValid & bus.idRegWr & ~bus.flush & ~w_stall &
                  (bus.idDest != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v  <= '0;
      r_wr <= '0;
      r_ld <= '0;
      for (int s = 0; s < 3; s++) begin
        r_dest[s] <= '0;
      end
    end else if (bus.hold) begin
      // Frozen pipeline: only a redirect may kill the EX occupant
      if (bus.flush) begin
        r_v[c_EX] <= 1'b0;
      end
    end else begin
      r_v[c_WB]     <= r_v[c_MEM];
      r_wr[c_WB]    <= r_wr[c_MEM];
      r_ld[c_WB]    <= r_ld[c_MEM];
      r_dest[c_WB]  <= r_dest[c_MEM];
      r_v[c_MEM]    <= r_v[c_EX];
      r_wr[c_MEM]   <= r_wr[c_EX];
      r_ld[c_MEM]   <= r_ld[c_EX];
      r_dest[c_MEM] <= r_dest[c_EX];
      r_v[c_EX]     <= w_ex_v;
      r_wr[c_EX]    <= bus.idRegWr;
      r_ld[c_EX]    <= bus.idIsLoad;
      r_dest[c_EX]  <= bus.idDest;
    end
  end

  assign bus.rsFwd     = w_rs_sel[DATA_W];
  assign bus.rsFwdData = w_rs_sel[DATA_W-1:0];
  assign bus.rtFwd     = w_rt_sel[DATA_W];
  assign bus.rtFwdData = w_rt_sel[DATA_W-1:0];
  assign bus.stall     = w_stall;

endmodule

`default_nettype wire

// File: tb/tb_forward_scoreboard.sv
// ============================================================================
// Module      : tb_forward_scoreboard
// Description : Directed and randomized checks of forward_scoreboard against a
//               producer-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_forward_scoreboard;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  forward_scoreboard_if bus ();

  forward_scoreboard dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // In-flight producers, youngest first: [0]=EX, [1]=MEM, [2]=WB
  typedef struct {
    bit v;
    int dest;
    bit ld;
  } prod_t;

  prod_t       pipe [3];
  bit          m_stall;
  bit          m_rsf;
  bit          m_rtf;
  logic [31:0] m_rsd;
  logic [31:0] m_rtd;

  task automatic lookup(input int r, input bit uses, output bit f, output logic [31:0] d);
    bit done;
    f = 0; d = '0; done = 0;
    if (uses && r != 0) begin
      for (int i = 0; i < 3; i++) begin
        if (!done && pipe[i].v && pipe[i].dest == r && !(i == 0 && pipe[i].ld)) begin
          f = 1;
          d = (i == 0) ? bus.exResult : (i == 1) ? bus.memResult : bus.wbResult;
          done = 1;
        end
      end
    end
  endtask

  function automatic bit load_pending(input int r, input bit uses);
    return uses && r != 0 && pipe[0].v && pipe[0].ld && pipe[0].dest == r;
  endfunction

  task automatic model_eval();
    m_stall = bus.idValid && !bus.flush &&
              (load_pending(int'(bus.idRs), bus.idUsesRs) ||
               load_pending(int'(bus.idRt), bus.idUsesRt));
    lookup(int'(bus.idRs), bus.idUsesRs, m_rsf, m_rsd);
    lookup(int'(bus.idRt), bus.idUsesRt, m_rtf, m_rtd);
  endtask

  task automatic set_id(input bit v, input int rs, input int rt, input bit urs,
                        input bit urt, input bit wr, input int dest, input bit ld);
    bus.idValid  = v;
    bus.idRs     = 5'(rs);
    bus.idRt     = 5'(rt);
    bus.idUsesRs = urs;
    bus.idUsesRt = urt;
    bus.idRegWr  = wr;
    bus.idDest   = 5'(dest);
    bus.idIsLoad = ld;
  endtask

  task automatic res(input logic [31:0] ex, input logic [31:0] mem, input logic [31:0] wb);
    bus.exResult  = ex;
    bus.memResult = mem;
    bus.wbResult  = wb;
  endtask

  // Settle, then compare the DUT against the model; operand selects are
  // don't-care while a stall is required.
  task automatic cyc(input string tag);
    #1;
    model_eval();
    check({tag, ".stall"}, 32'(bus.stall), 32'(m_stall));
    if (!m_stall) begin
      check({tag, ".rsFwd"}, 32'(bus.rsFwd), 32'(m_rsf));
      check({tag, ".rsData"}, bus.rsFwdData, m_rsd);
      check({tag, ".rtFwd"}, 32'(bus.rtFwd), 32'(m_rtf));
      check({tag, ".rtData"}, bus.rtFwdData, m_rtd);
    end
  endtask

  task automatic adv();
    model_eval();
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) pipe[i].v = 0;
    end else if (bus.hold) begin
      if (bus.flush) pipe[0].v = 0;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0].v    = bus.idValid && bus.idRegWr && !bus.flush && !m_stall && bus.idDest != 0;
      pipe[0].dest = int'(bus.idDest);
      pipe[0].ld   = bus.idIsLoad;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      cyc("idle");
      adv();
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0};
    bus.hold  = 0;
    bus.flush = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    res('0, '0, '0);
    @(negedge clk);
    adv();
    adv();

    // Reset state
    rst_n = 1;
    set_id(1, 5, 5, 1, 1, 0, 0, 0);
    cyc("rst");
    check("rst.rsFwd", 32'(bus.rsFwd), 32'd0);
    check("rst.rtFwd", 32'(bus.rtFwd), 32'd0);
    check("rst.stall", 32'(bus.stall), 32'd0);
    adv();

    // EX forward, then EX/MEM/WB priority
    res(32'h1234, 32'hAAAA, 32'hCCCC);
    set_id(1, 0, 0, 0, 0, 1, 8, 0);
    cyc("exA");
    adv();
    set_id(1, 8, 0, 1, 0, 1, 8, 0);
    cyc("exB");
    check("ex.rsFwd", 32'(bus.rsFwd), 32'd1);
    check("ex.rsData", bus.rsFwdData, 32'h0000_1234);
    check("ex.stall", 32'(bus.stall), 32'd0);
    adv();
    res(32'hBBBB, 32'hAAAA, 32'hCCCC);
    set_id(1, 8, 0, 1, 0, 0, 0, 0);
    cyc("prioEx");
    check("prio.ex_over_mem", bus.rsFwdData, 32'hBBBB);
    adv();
    cyc("prioMem");
    check("prio.mem", bus.rsFwdData, 32'hAAAA);
    adv();
    cyc("prioWb");
    check("prio.wb", bus.rsFwdData, 32'hCCCC);
    adv();

    // Load-use, no hold
    idle(3);
    res(32'h1111, 32'hDEAD_BEEF, 32'h2222);
    set_id(1, 0, 0, 0, 0, 1, 9, 1);
    cyc("lw");
    adv();
    set_id(1, 0, 9, 0, 1, 0, 0, 0);
    cyc("lu1");
    check("lu.stall1", 32'(bus.stall), 32'd1);
    adv();
    cyc("lu2");
    check("lu.stall2", 32'(bus.stall), 32'd0);
    check("lu.rtFwd", 32'(bus.rtFwd), 32'd1);
    check("lu.rtData", bus.rtFwdData, 32'hDEAD_BEEF);
    adv();

    // Load-use across hold cycles
    idle(3);
    set_id(1, 0, 0, 0, 0, 1, 9, 1);
    cyc("lwh");
    adv();
    set_id(1, 0, 9, 0, 1, 0, 0, 0);
    bus.hold = 1;
    for (int i = 0; i < 3; i++) begin
      cyc("luh");
      check("luh.stall", 32'(bus.stall), 32'd1);
      adv();
    end
    bus.hold = 0;
    cyc("luh.rel");
    check("luh.stall_rel", 32'(bus.stall), 32'd1);
    adv();
    cyc("luh.fwd");
    check("luh.stall_done", 32'(bus.stall), 32'd0);
    check("luh.rtData", bus.rtFwdData, 32'hDEAD_BEEF);
    adv();

    // $zero and flush
    idle(3);
    set_id(1, 0, 0, 0, 0, 1, 0, 0);
    cyc("zw");
    adv();
    set_id(1, 0, 0, 1, 0, 0, 0, 0);
    cyc("zr");
    check("zero.rsFwd", 32'(bus.rsFwd), 32'd0);
    adv();
    set_id(1, 0, 0, 0, 0, 1, 7, 0);
    bus.flush = 1;
    cyc("fw");
    adv();
    bus.flush = 0;
    set_id(1, 7, 0, 1, 0, 0, 0, 0);
    cyc("fr");
    check("flush.rsFwd", 32'(bus.rsFwd), 32'd0);
    adv();

    // Reset with every slot occupied
    idle(3);
    for (int d = 10; d <= 12; d++) begin
      set_id(1, 0, 0, 0, 0, 1, d, 0);
      cyc("mrw");
      adv();
    end
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 0;
    cyc("mrst");
    adv();
    rst_n = 1;
    set_id(1, 10, 11, 1, 1, 0, 0, 0);
    cyc("mr1");
    check("mr.rsFwd", 32'(bus.rsFwd), 32'd0);
    check("mr.rtFwd", 32'(bus.rtFwd), 32'd0);
    check("mr.stall", 32'(bus.stall), 32'd0);
    adv();
    set_id(1, 12, 12, 1, 1, 0, 0, 0);
    cyc("mr2");
    check("mr.rsFwd12", 32'(bus.rsFwd), 32'd0);
    adv();

    // Randomized traffic over a small register window to force collisions
    for (int n = 0; n < 3000; n++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      bus.hold  = ($urandom_range(0, 4) == 0);
      bus.flush = ($urandom_range(0, 7) == 0);
      set_id($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
             $urandom_range(0, 7), $urandom_range(0, 2) == 0);
      res($urandom, $urandom, $urandom);
      cyc("rnd");
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
